// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler and its divide sequencer.
package pipe_ctrl_pkg;

    // Divide sequencer state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divState_t;

    // Default divider iteration count (start to result valid)
    localparam int DIV_CYCLES_DEF = 32;

    // $zero never creates a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush scheduler.
interface pipe_hazard_ctrl_if;
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic       branchD;
    logic [4:0] writeregE;
    logic       RegWriteE;
    logic       MemtoRegE;
    logic [4:0] writeregM;
    logic       MemtoRegM;
    logic       divE;
    logic       dmem_stallM;
    logic       exceptM;

    logic       stallF;
    logic       stallD;
    logic       stallE;
    logic       stallM;
    logic       stallW;
    logic       flushD;
    logic       flushE;
    logic       flushM;
    logic       flushW;
    logic       div_start;
    logic       div_cancel;
    logic       div_busy;

    // Datapath side: reports instruction state, receives stage controls
    modport master (
        output rsD, rtD, branchD, writeregE, RegWriteE, MemtoRegE,
               writeregM, MemtoRegM, divE, dmem_stallM, exceptM,
        input  stallF, stallD, stallE, stallM, stallW,
               flushD, flushE, flushM, flushW,
               div_start, div_cancel, div_busy
    );

    // Scheduler side
    modport slave (
        input  rsD, rtD, branchD, writeregE, RegWriteE, MemtoRegE,
               writeregM, MemtoRegM, divE, dmem_stallM, exceptM,
        output stallF, stallD, stallE, stallM, stallW,
               flushD, flushE, flushM, flushW,
               div_start, div_cancel, div_busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl_div_seq.sv
// Iterative-divider sequencer: issues start/cancel pulses and tracks occupancy
// so the HI/LO result reaches M/W exactly once.
module div_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic divE,
    input  logic hold,
    input  logic abort,
    output logic div_start,
    output logic div_cancel,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);

    divState_t        state;
    divState_t        stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;

    // State and iteration counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next-state and pulse decode; abort overrides everything, memory wait
    // only holds DONE (the divider itself keeps iterating)
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        div_start  = 1'b0;
        div_cancel = 1'b0;
        if (abort) begin
            div_cancel = (state != IDLE);
            stateNext  = IDLE;
            cntNext    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (divE && !hold) begin
                        div_start = 1'b1;
                        stateNext = BUSY;
                        cntNext   = '0;
                    end
                end
                BUSY: begin
                    cntNext = cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        stateNext = DONE;
                        cntNext   = '0;
                    end
                end
                DONE: begin
                    // divE here is the same div instruction moving on; never restart
                    if (!hold) begin
                        stateNext = IDLE;
                    end
                end
                default: begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for the five pipeline registers
// (PC, F/D, D/E, E/M, M/W). Priority: exception > memory wait > divide > hazard.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
);

    logic divBusy;
    logic divDone;
    logic divStall;
    logic srcHitE;
    logic srcHitM;
    logic loadUse;
    logic branchHaz;
    logic hazard;

    div_seq #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) uDivSeq (
        .clk        (clk),
        .reset      (reset),
        .divE       (hz.divE),
        .hold       (hz.dmem_stallM),
        .abort      (hz.exceptM),
        .div_start  (hz.div_start),
        .div_cancel (hz.div_cancel),
        .busy       (divBusy),
        .done       (divDone)
    );

    // DONE releases the stall so the div result can advance into M
    assign divStall    = divBusy && !divDone;
    assign hz.div_busy = divBusy;

    // Operand matches against non-zero destinations in E and M
    assign srcHitE = (hz.writeregE != REG_ZERO) &&
                     ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD));
    assign srcHitM = (hz.writeregM != REG_ZERO) &&
                     ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD));

    assign loadUse   = hz.MemtoRegE && hz.RegWriteE && srcHitE;
    // Branches compare in D, so an ALU result in E or a load in M is not yet forwardable
    assign branchHaz = hz.branchD && ((hz.RegWriteE && srcHitE) || (hz.MemtoRegM && srcHitM));
    assign hazard    = loadUse || branchHaz;

    // Priority mux of stage enables and clears
    always_comb begin
        hz.stallF = 1'b0;
        hz.stallD = 1'b0;
        hz.stallE = 1'b0;
        hz.stallM = 1'b0;
        hz.stallW = 1'b0;
        hz.flushD = 1'b0;
        hz.flushE = 1'b0;
        hz.flushM = 1'b0;
        hz.flushW = 1'b0;
        if (hz.exceptM) begin
            hz.flushD = 1'b1;
            hz.flushE = 1'b1;
            hz.flushM = 1'b1;
            hz.flushW = 1'b1;
        end else if (hz.dmem_stallM) begin
            // Freeze F..M and feed a bubble into W while memory finishes
            hz.stallF = 1'b1;
            hz.stallD = 1'b1;
            hz.stallE = 1'b1;
            hz.stallM = 1'b1;
            hz.flushW = 1'b1;
        end else if (divStall) begin
            hz.stallF = 1'b1;
            hz.stallD = 1'b1;
            hz.stallE = 1'b1;
            hz.flushM = 1'b1;
        end else if (hazard) begin
            hz.stallF = 1'b1;
            hz.stallD = 1'b1;
            hz.flushE = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for the pipeline stall/flush scheduler (divider shortened to 4 cycles).
module tb_pipe_hazard_ctrl;

    logic clk;
    logic reset;
    int   nChecks;
    int   nFails;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl #(
        .DIV_CYCLES (4),
        .CNT_W      (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: {stallF,stallD,stallE,stallM,stallW, flushD,flushE,flushM,flushW, div_start,div_cancel,div_busy}
    function automatic logic [11:0] outv();
        return {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.stallW,
                hz.flushD, hz.flushE, hz.flushM, hz.flushW,
                hz.div_start, hz.div_cancel, hz.div_busy};
    endfunction

    task automatic clearInputs();
        hz.rsD         = 5'd0;
        hz.rtD         = 5'd0;
        hz.branchD     = 1'b0;
        hz.writeregE   = 5'd0;
        hz.RegWriteE   = 1'b0;
        hz.MemtoRegE   = 1'b0;
        hz.writeregM   = 5'd0;
        hz.MemtoRegM   = 1'b0;
        hz.divE        = 1'b0;
        hz.dmem_stallM = 1'b0;
        hz.exceptM     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clearInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        nChecks++;
        if (outv() !== 12'b0) begin
            nFails++;
            $display("FAIL reset_outputs: got %b want %b", outv(), 12'b0);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        nChecks++;
        if (outv() !== 12'b0) begin
            nFails++;
            $display("FAIL after_reset_idle: got %b want %b", outv(), 12'b0);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [11:0] expV;
        // 0: rs match, 1: idle next cycle, 2: rt match, 3: $zero dest, 4: not a load write
        for (int c = 0; c < 5; c++) begin
            clearInputs();
            case (c)
                0: begin hz.MemtoRegE = 1; hz.RegWriteE = 1; hz.writeregE = 5'd8; hz.rsD = 5'd8; end
                2: begin hz.MemtoRegE = 1; hz.RegWriteE = 1; hz.writeregE = 5'd9; hz.rtD = 5'd9; hz.rsD = 5'd1; end
                3: begin hz.MemtoRegE = 1; hz.RegWriteE = 1; hz.writeregE = 5'd0; end
                4: begin hz.MemtoRegE = 1; hz.RegWriteE = 0; hz.writeregE = 5'd8; hz.rsD = 5'd8; end
                default: ;
            endcase
            expV = (c == 0 || c == 2) ? {5'b11000, 4'b0100, 3'b000} : 12'b0;
            @(negedge clk);
            nChecks++;
            if (outv() !== expV) begin
                nFails++;
                $display("FAIL load_use[%0d]: got %b want %b", c, outv(), expV);
            end
            tick();
        end
        clearInputs();
    endtask

    task automatic test_branch();
        logic [11:0] expV;
        // 0: load in M, 1: same with exception, 2: ALU write in E, 3: $zero in M,
        // 4: load in M without branch, 5: load-use under memory wait
        for (int c = 0; c < 6; c++) begin
            clearInputs();
            case (c)
                0: begin hz.branchD = 1; hz.rtD = 5'd3; hz.MemtoRegM = 1; hz.writeregM = 5'd3; end
                1: begin hz.branchD = 1; hz.rtD = 5'd3; hz.MemtoRegM = 1; hz.writeregM = 5'd3; hz.exceptM = 1; end
                2: begin hz.branchD = 1; hz.rsD = 5'd12; hz.RegWriteE = 1; hz.writeregE = 5'd12; end
                3: begin hz.branchD = 1; hz.MemtoRegM = 1; hz.writeregM = 5'd0; end
                4: begin hz.rtD = 5'd3; hz.MemtoRegM = 1; hz.writeregM = 5'd3; end
                5: begin hz.MemtoRegE = 1; hz.RegWriteE = 1; hz.writeregE = 5'd8; hz.rsD = 5'd8; hz.dmem_stallM = 1; end
                default: ;
            endcase
            case (c)
                0, 2:    expV = {5'b11000, 4'b0100, 3'b000};
                1:       expV = {5'b00000, 4'b1111, 3'b000};
                5:       expV = {5'b11110, 4'b0001, 3'b000};
                default: expV = 12'b0;
            endcase
            @(negedge clk);
            nChecks++;
            if (outv() !== expV) begin
                nFails++;
                $display("FAIL branch[%0d]: got %b want %b", c, outv(), expV);
            end
            tick();
        end
        clearInputs();
    endtask

    task automatic test_divide();
        logic [11:0] expTab [7];
        expTab[0] = {5'b00000, 4'b0000, 3'b100};
        for (int i = 1; i <= 4; i++) expTab[i] = {5'b11100, 4'b0010, 3'b001};
        expTab[5] = {5'b00000, 4'b0000, 3'b001};
        expTab[6] = 12'b0;
        for (int c = 0; c < 7; c++) begin
            // divE reappears in DONE as the same instruction; must not restart
            hz.divE = (c == 0 || c == 5);
            @(negedge clk);
            nChecks++;
            if (outv() !== expTab[c]) begin
                nFails++;
                $display("FAIL divide[%0d]: got %b want %b", c, outv(), expTab[c]);
            end
            tick();
        end
        clearInputs();
    endtask

    task automatic test_mem_over_done();
        logic [11:0] expTab [9];
        expTab[0] = {5'b00000, 4'b0000, 3'b100};
        for (int i = 1; i <= 3; i++) expTab[i] = {5'b11100, 4'b0010, 3'b001};
        for (int i = 4; i <= 6; i++) expTab[i] = {5'b11110, 4'b0001, 3'b001};
        expTab[7] = {5'b00000, 4'b0000, 3'b001};
        expTab[8] = 12'b0;
        for (int c = 0; c < 9; c++) begin
            hz.divE        = (c == 0);
            hz.dmem_stallM = (c >= 4 && c <= 6);
            @(negedge clk);
            nChecks++;
            if (outv() !== expTab[c]) begin
                nFails++;
                $display("FAIL mem_over_done[%0d]: got %b want %b", c, outv(), expTab[c]);
            end
            tick();
        end
        clearInputs();
    endtask

    task automatic test_exception();
        logic [11:0] expTab [7];
        expTab[0] = {5'b00000, 4'b0000, 3'b100};
        expTab[1] = {5'b11100, 4'b0010, 3'b001};
        expTab[2] = {5'b11100, 4'b0010, 3'b001};
        expTab[3] = {5'b00000, 4'b1111, 3'b011};
        expTab[4] = 12'b0;
        expTab[5] = {5'b00000, 4'b1111, 3'b000};
        expTab[6] = 12'b0;
        for (int c = 0; c < 7; c++) begin
            hz.divE    = (c == 0 || c == 5);
            hz.exceptM = (c == 3 || c == 5);
            @(negedge clk);
            nChecks++;
            if (outv() !== expTab[c]) begin
                nFails++;
                $display("FAIL exception[%0d]: got %b want %b", c, outv(), expTab[c]);
            end
            tick();
        end
        clearInputs();
    endtask

    task automatic test_back_to_back();
        logic [11:0] expTab [5];
        expTab[0] = {5'b00000, 4'b0000, 3'b100};
        expTab[1] = {5'b11100, 4'b0010, 3'b001};
        expTab[2] = {5'b11100, 4'b0010, 3'b001};
        expTab[3] = {5'b00000, 4'b1111, 3'b011};
        expTab[4] = {5'b11000, 4'b0100, 3'b000};
        for (int c = 0; c < 5; c++) begin
            clearInputs();
            hz.divE = (c == 0);
            if (c >= 1) begin
                hz.MemtoRegE = 1; hz.RegWriteE = 1; hz.writeregE = 5'd7; hz.rtD = 5'd7;
            end
            hz.exceptM = (c == 3);
            @(negedge clk);
            nChecks++;
            if (outv() !== expTab[c]) begin
                nFails++;
                $display("FAIL hazard_vs_busy[%0d]: got %b want %b", c, outv(), expTab[c]);
            end
            tick();
        end
        clearInputs();
    endtask

    task automatic test_async_reset();
        hz.divE = 1'b1;
        tick();
        hz.divE = 1'b0;
        #2;
        nChecks++;
        if (outv() !== {5'b11100, 4'b0010, 3'b001}) begin
            nFails++;
            $display("FAIL async_pre_busy: got %b want %b", outv(), {5'b11100, 4'b0010, 3'b001});
        end
        reset = 1'b1;
        #1;
        nChecks++;
        if (outv() !== 12'b0) begin
            nFails++;
            $display("FAIL async_reset_immediate: got %b want %b", outv(), 12'b0);
        end
        #1;
        reset = 1'b0;
        @(negedge clk);
        nChecks++;
        if (outv() !== 12'b0) begin
            nFails++;
            $display("FAIL async_reset_after: got %b want %b", outv(), 12'b0);
        end
        tick();
        @(negedge clk);
        nChecks++;
        if (outv() !== 12'b0) begin
            nFails++;
            $display("FAIL async_reset_stays_idle: got %b want %b", outv(), 12'b0);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        nChecks = 0;
        nFails  = 0;
        test_reset();
        test_load_use();
        test_branch();
        test_divide();
        test_mem_over_done();
        test_exception();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
